// File: rtl/hdr_pkg.sv
// hdr_pkg: shared types and helpers for the HDR exposure fetch block.
package hdr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StEmit
    } hdr_state_e;

    // Counter width for n distinct values, never below one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Frame slot written `age` frames before `slot` in a ring of `num_exp` slots.
    function automatic int unsigned slot_age(input int unsigned slot, input int unsigned age,
                                             input int unsigned num_exp);
        return (slot + num_exp - age) % num_exp;
    endfunction

endpackage

// File: rtl/hdr_lane_unpack.sv
// hdr_lane_unpack: selects one pixel out of a lane word.
// HDR_FETCH_BYTESWAP_EN: when defined, the selected pixel is byte-swapped (big-endian sensor).
module hdr_lane_unpack #(
    parameter int unsigned BUS_W = 128,
    parameter int unsigned PIX_W = 16,
    parameter int unsigned IDX_W = 3
) (
    input  logic [BUS_W-1:0] word_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [PIX_W-1:0] pix_o
);

    localparam int unsigned BaseW = $clog2(BUS_W);

    logic [BaseW-1:0] base;
    logic [PIX_W-1:0] raw;

    // Pixel extraction and optional byte reordering.
    always_comb begin
        base = BaseW'(idx_i) * BaseW'(PIX_W);
        raw  = word_i[base +: PIX_W];
`ifdef HDR_FETCH_BYTESWAP_EN
        pix_o = {raw[PIX_W/2-1:0], raw[PIX_W-1:PIX_W/2]};
`else
        pix_o = raw;
`endif
    end

endmodule

// File: rtl/hdr_exposure_fetch.sv
// hdr_exposure_fetch: for each live camera word, reads the co-located words of the NUM_EXP-1
// older exposures from the frame-slot ring and emits NUM_EXP-lane pixel tuples.
// HDR_FETCH_BYTESWAP_EN: byte-swaps every output pixel (see hdr_lane_unpack).
module hdr_exposure_fetch
    import hdr_pkg::*;
#(
    parameter int unsigned       NUM_EXP         = 3,
    parameter int unsigned       BUS_W           = 128,
    parameter int unsigned       PIX_W           = 16,
    parameter int unsigned       ADDR_W          = 25,
    parameter logic [ADDR_W-1:0] SLOT_BASE       = '0,
    parameter logic [ADDR_W-1:0] SLOT_STRIDE     = ADDR_W'(32'h25800),
    parameter int unsigned       ADDR_STEP       = 4,
    parameter int unsigned       WORDS_PER_FRAME = 38400,
    localparam int unsigned      SLOT_W          = cnt_w(NUM_EXP)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     hdr_en_i,
    input  logic                     frame_done_i,
    input  logic [SLOT_W-1:0]        cur_slot_i,
    input  logic                     camera_wr_req_i,
    input  logic [BUS_W-1:0]         camera_data_i,
    input  logic                     ram_busy_i,
    output logic                     rd_req_o,
    output logic [ADDR_W-1:0]        rd_address_o,
    input  logic                     rd_valid_i,
    input  logic [BUS_W-1:0]         rd_data_i,
    output logic                     pix_valid_o,
    input  logic                     pix_ready_i,
    output logic [NUM_EXP*PIX_W-1:0] pix_data_o,
    output logic                     pix_last_o,
    output logic                     err_overrun_o
);

    localparam int unsigned PPW   = BUS_W / PIX_W;
    localparam int unsigned IDX_W = cnt_w(PPW);
    localparam int unsigned OFF_W = cnt_w(WORDS_PER_FRAME);

    hdr_state_e state_q, state_d;

    logic [BUS_W-1:0]  lane_q [NUM_EXP];
    logic [BUS_W-1:0]  lane_d [NUM_EXP];
    logic [PIX_W-1:0]  lane_pix [NUM_EXP];
    logic [SLOT_W-1:0] k_q, k_d;
    logic [SLOT_W-1:0] rsp_q, rsp_d;
    logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;
    logic [OFF_W-1:0]  word_off_q, word_off_d;  // offset the next camera word will use
    logic [OFF_W-1:0]  cur_off_q, cur_off_d;    // offset of the word being processed
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              pend_q, pend_d;          // frame_done seen while busy
    logic [SLOT_W-1:0] pend_slot_q, pend_slot_d;
    logic              err_q, err_d;

    logic              in_idle, accept, drop, req_fire, last_req, rsp_take, last_rsp;
    logic              hs, last_pix;
    logic [SLOT_W-1:0] eff_slot, wr_lane;
    logic [OFF_W-1:0]  eff_off;

    function automatic logic [OFF_W-1:0] off_inc(input logic [OFF_W-1:0] off);
        return (off == OFF_W'(WORDS_PER_FRAME - 1)) ? '0 : off + OFF_W'(1);
    endfunction

    // Handshake and phase decode shared by the FSM and datapath.
    always_comb begin
        in_idle  = (state_q == StIdle);
        accept   = in_idle & camera_wr_req_i & hdr_en_i;
        drop     = ~in_idle & camera_wr_req_i & hdr_en_i;
        req_fire = (state_q == StReq) & ~ram_busy_i;
        last_req = (k_q == SLOT_W'(NUM_EXP - 1));
        rsp_take = rd_valid_i & ((state_q == StReq) | (state_q == StWait));
        last_rsp = (rsp_q == SLOT_W'(NUM_EXP - 2));
        wr_lane  = rsp_q + SLOT_W'(1);
        hs       = (state_q == StEmit) & pix_ready_i;
        last_pix = (pix_idx_q == IDX_W'(PPW - 1));
    end

    // Frame boundary takes effect before a word accepted in the same idle cycle.
    always_comb begin
        if (frame_done_i) begin
            eff_slot = cur_slot_i;
            eff_off  = '0;
        end else if (pend_q) begin
            eff_slot = pend_slot_q;
            eff_off  = '0;
        end else begin
            eff_slot = slot_q;
            eff_off  = word_off_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StReq;
            StReq: begin
                if (rsp_take && last_rsp) begin
                    state_d = StEmit;
                end else if (req_fire && last_req) begin
                    state_d = StWait;
                end
            end
            StWait: if (rsp_take && last_rsp) state_d = StEmit;
            StEmit: if (hs && last_pix) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: read request, address and tuple presentation.
    always_comb begin
        int unsigned age;
        age          = slot_age(32'(slot_q), 32'(k_q), NUM_EXP);
        rd_req_o     = req_fire;
        rd_address_o = '0;
        if (state_q == StReq) begin
            rd_address_o = SLOT_BASE + ADDR_W'(age) * SLOT_STRIDE
                         + ADDR_W'(cur_off_q) * ADDR_W'(ADDR_STEP);
        end
        pix_valid_o = (state_q == StEmit);
        pix_last_o  = (state_q == StEmit) & last_pix
                    & (cur_off_q == OFF_W'(WORDS_PER_FRAME - 1));
        for (int i = 0; i < NUM_EXP; i++) begin
            pix_data_o[i*PIX_W +: PIX_W] = (state_q == StEmit) ? lane_pix[i] : '0;
        end
    end

    assign err_overrun_o = err_q;

    // Datapath next-state: lane capture, counters, slot and offset tracking.
    always_comb begin
        lane_d      = lane_q;
        k_d         = k_q;
        rsp_d       = rsp_q;
        pix_idx_d   = pix_idx_q;
        word_off_d  = word_off_q;
        cur_off_d   = cur_off_q;
        slot_d      = slot_q;
        pend_d      = pend_q;
        pend_slot_d = pend_slot_q;
        err_d       = drop;
        if (in_idle) begin
            slot_d     = eff_slot;
            word_off_d = eff_off;
            pend_d     = 1'b0;
            if (accept) begin
                lane_d[0]  = camera_data_i;
                k_d        = SLOT_W'(1);
                rsp_d      = '0;
                pix_idx_d  = '0;
                cur_off_d  = eff_off;
                word_off_d = off_inc(eff_off);
            end
        end else begin
            if (frame_done_i) begin
                pend_d      = 1'b1;
                pend_slot_d = cur_slot_i;
            end
            // A dropped word still consumes an offset so later addresses stay aligned.
            if (drop) word_off_d = off_inc(word_off_q);
            if (req_fire) k_d = k_q + SLOT_W'(1);
            if (rsp_take) begin
                lane_d[wr_lane] = rd_data_i;
                rsp_d           = rsp_q + SLOT_W'(1);
            end
            if (hs) pix_idx_d = last_pix ? '0 : pix_idx_q + IDX_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_EXP; i++) lane_q[i] <= '0;
            k_q         <= '0;
            rsp_q       <= '0;
            pix_idx_q   <= '0;
            word_off_q  <= '0;
            cur_off_q   <= '0;
            slot_q      <= '0;
            pend_q      <= 1'b0;
            pend_slot_q <= '0;
            err_q       <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            k_q         <= k_d;
            rsp_q       <= rsp_d;
            pix_idx_q   <= pix_idx_d;
            word_off_q  <= word_off_d;
            cur_off_q   <= cur_off_d;
            slot_q      <= slot_d;
            pend_q      <= pend_d;
            pend_slot_q <= pend_slot_d;
            err_q       <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_EXP; g++) begin : g_lane
        hdr_lane_unpack #(
            .BUS_W(BUS_W),
            .PIX_W(PIX_W),
            .IDX_W(IDX_W)
        ) u_unpack (
            .word_i(lane_q[g]),
            .idx_i (pix_idx_q),
            .pix_o (lane_pix[g])
        );
    end

endmodule

// File: tb/tb_hdr_exposure_fetch.sv
// tb_hdr_exposure_fetch: directed test of the exposure fetch block (NUM_EXP=3, 4 words/frame).
module tb_hdr_exposure_fetch;

    localparam int unsigned NumExp = 3;
    localparam int unsigned BusW   = 128;
    localparam int unsigned PixW   = 16;
    localparam int unsigned AddrW  = 25;
    localparam int unsigned Wpf    = 4;
`ifdef HDR_FETCH_BYTESWAP_EN
    localparam logic [15:0] SwapRef = 16'h3412;
`else
    localparam logic [15:0] SwapRef = 16'h1234;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   hdr_en, frame_done, camera_wr_req, ram_busy, rd_valid, pix_ready;
    logic [1:0]             cur_slot;
    logic [BusW-1:0]        camera_data, rd_data;
    logic                   rd_req, pix_valid, pix_last, err_overrun;
    logic [AddrW-1:0]       rd_address;
    logic [NumExp*PixW-1:0] pix_data;

    int               cyc = 0;
    int               n_checks = 0;
    int               n_errors = 0;
    logic [AddrW-1:0] req_log[$];
    int               req_cyc[$];
    logic [AddrW-1:0] pend_addr[$];
    int               pend_due[$];
    int               rsp_last_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hdr_exposure_fetch #(
        .NUM_EXP        (NumExp),
        .BUS_W          (BusW),
        .PIX_W          (PixW),
        .ADDR_W         (AddrW),
        .WORDS_PER_FRAME(Wpf)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .hdr_en_i       (hdr_en),
        .frame_done_i   (frame_done),
        .cur_slot_i     (cur_slot),
        .camera_wr_req_i(camera_wr_req),
        .camera_data_i  (camera_data),
        .ram_busy_i     (ram_busy),
        .rd_req_o       (rd_req),
        .rd_address_o   (rd_address),
        .rd_valid_i     (rd_valid),
        .rd_data_i      (rd_data),
        .pix_valid_o    (pix_valid),
        .pix_ready_i    (pix_ready),
        .pix_data_o     (pix_data),
        .pix_last_o     (pix_last),
        .err_overrun_o  (err_overrun)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PixW-1:0] mem_pix(input logic [AddrW-1:0] a, input int p);
        return PixW'(a >> 4) ^ PixW'(p * 32'h1111) ^ 16'h00A5;
    endfunction

    function automatic logic [BusW-1:0] mem_word(input logic [AddrW-1:0] a);
        logic [BusW-1:0] w;
        for (int p = 0; p < 8; p++) w[p*PixW +: PixW] = mem_pix(a, p);
        return w;
    endfunction

    function automatic logic [BusW-1:0] cam_word(input logic [7:0] seed);
        logic [BusW-1:0] w;
        for (int p = 0; p < 8; p++) w[p*PixW +: PixW] = {seed, 8'(p)};
        return w;
    endfunction

    function automatic logic [PixW-1:0] out_pix(input logic [BusW-1:0] w, input int p);
        logic [PixW-1:0] raw;
        raw = w[p*PixW +: PixW];
`ifdef HDR_FETCH_BYTESWAP_EN
        return {raw[7:0], raw[15:8]};
`else
        return raw;
`endif
    endfunction

    function automatic logic [NumExp*PixW-1:0] exp_tuple(input logic [BusW-1:0] w,
                                                         input logic [AddrW-1:0] a1,
                                                         input logic [AddrW-1:0] a2,
                                                         input int p);
        return {out_pix(mem_word(a2), p), out_pix(mem_word(a1), p), out_pix(w, p)};
    endfunction

    // RAM model: in-order responses two cycles after each request.
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rd_req) begin
                req_log.push_back(rd_address);
                req_cyc.push_back(cyc);
                pend_addr.push_back(rd_address);
                pend_due.push_back(cyc + 2);
            end
            @(posedge clk);
            #1;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                rd_valid     = 1'b1;
                rd_data      = mem_word(pend_addr[0]);
                rsp_last_cyc = cyc;
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                rd_valid = 1'b0;
            end
        end
    end

    // One camera word end to end; rel counts cycles after the camera pulse.
    task automatic do_word(input string name, input logic [BusW-1:0] w,
                           input logic [AddrW-1:0] a1, input logic [AddrW-1:0] a2,
                           input int busy, input int drop_at, input int stall_at,
                           input int fd_at, input logic [1:0] fd_slot, input logic fd_with_cam,
                           input logic en_low, input logic exp_last);
        int t0, rel, npix, stall_cnt, first_valid, err_cnt, exp_err;
        req_log.delete();
        req_cyc.delete();
        @(posedge clk);
        #1;
        t0            = cyc;
        hdr_en        = 1'b1;
        camera_wr_req = 1'b1;
        camera_data   = w;
        ram_busy      = (busy > 0);
        if (fd_with_cam) begin
            frame_done = 1'b1;
            cur_slot   = fd_slot;
        end
        npix        = 0;
        stall_cnt   = 0;
        first_valid = -1;
        err_cnt     = 0;
        rel         = 0;
        exp_err     = (drop_at > 0 && !en_low) ? 1 : 0;
        @(negedge clk);
        while (npix < 8 && rel < 60) begin
            @(posedge clk);
            #1;
            rel++;
            camera_wr_req = (rel == drop_at);
            camera_data   = ~w;
            frame_done    = (rel == fd_at);
            cur_slot      = (rel == fd_at) ? fd_slot : 2'd0;
            ram_busy      = (rel <= busy);
            pix_ready     = !(npix == stall_at && stall_cnt < 3);
            if (en_low) hdr_en = 1'b0;
            @(negedge clk);
            if (err_overrun) err_cnt++;
            if (pix_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check_eq({name, "/pix"}, 64'(pix_data), 64'(exp_tuple(w, a1, a2, npix)));
                check_eq({name, "/last"}, 64'(pix_last), 64'(exp_last && npix == 7));
                if (npix == 0 && w[15:0] == 16'h1234) begin
                    check_eq({name, "/swap"}, 64'(pix_data[15:0]), 64'(SwapRef));
                end
                if (pix_ready) npix++;
                else stall_cnt++;
            end
        end
        camera_wr_req = 1'b0;
        frame_done    = 1'b0;
        ram_busy      = 1'b0;
        pix_ready     = 1'b1;
        hdr_en        = 1'b1;
        check_eq({name, "/tuples"}, 64'(npix), 64'd8);
        @(posedge clk);
        #1;
        @(negedge clk);
        if (err_overrun) err_cnt++;
        check_eq({name, "/idle"}, 64'(pix_valid), 64'd0);
        check_eq({name, "/nreq"}, 64'(req_log.size()), 64'd2);
        if (req_log.size() >= 2) begin
            check_eq({name, "/addr1"}, 64'(req_log[0]), 64'(a1));
            check_eq({name, "/addr2"}, 64'(req_log[1]), 64'(a2));
            check_eq({name, "/req_lat"}, 64'(req_cyc[0] - t0), 64'(1 + busy));
        end
        check_eq({name, "/emit_lat"}, 64'(first_valid - rsp_last_cyc), 64'd1);
        check_eq({name, "/overrun"}, 64'(err_cnt), 64'(exp_err));
    endtask

    initial begin
        logic [BusW-1:0] w1;
        int              seen;
        rst           = 1'b1;
        hdr_en        = 1'b1;
        frame_done    = 1'b0;
        cur_slot      = 2'd0;
        camera_wr_req = 1'b0;
        camera_data   = '0;
        ram_busy      = 1'b0;
        pix_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst/rd_req", 64'(rd_req), 64'd0);
        check_eq("rst/rd_address", 64'(rd_address), 64'd0);
        check_eq("rst/pix_valid", 64'(pix_valid), 64'd0);
        check_eq("rst/pix_last", 64'(pix_last), 64'd0);
        check_eq("rst/err_overrun", 64'(err_overrun), 64'd0);
        check_eq("rst/pix_data", 64'(pix_data), 64'd0);

        w1        = cam_word(8'h11);
        w1[15:0]  = 16'h1234;
        // name, word, addr1, addr2, busy, drop_at, stall_at, fd_at, fd_slot, fd_cam, en_low, last
        do_word("basic",   w1,              25'h4B000, 25'h25800, 0, 0, -1, 0, 2'd0, 0, 0, 0);
        do_word("overrun", cam_word(8'h22), 25'h4B004, 25'h25804, 0, 3, -1, 0, 2'd0, 0, 0, 0);
        do_word("busy",    cam_word(8'h33), 25'h4B00C, 25'h2580C, 5, 0, -1, 0, 2'd0, 0, 0, 1);
        do_word("stall",   cam_word(8'h44), 25'h4B000, 25'h25800, 0, 0, 3, 9, 2'd2, 0, 0, 0);
        do_word("newslot", cam_word(8'h55), 25'h25800, 25'h00000, 0, 0, -1, 0, 2'd0, 0, 0, 0);
        do_word("fd_cam",  cam_word(8'h66), 25'h00000, 25'h4B000, 0, 0, -1, 0, 2'd1, 1, 0, 0);
        do_word("en_low",  cam_word(8'h77), 25'h00004, 25'h4B004, 0, 3, -1, 0, 2'd0, 0, 1, 0);

        // Disabled block must ignore camera words entirely.
        req_log.delete();
        @(posedge clk);
        #1;
        hdr_en        = 1'b0;
        camera_wr_req = 1'b1;
        camera_data   = cam_word(8'h88);
        seen          = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pix_valid || err_overrun) seen++;
            @(posedge clk);
            #1;
            camera_wr_req = 1'b0;
        end
        check_eq("disabled/nreq", 64'(req_log.size()), 64'd0);
        check_eq("disabled/activity", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
